// File: rtl/sequential_divider.sv
// Sequential restoring divider. Produces one quotient bit per clock, MSB
// first, so a WIDTH-bit division takes WIDTH clocks after the start is
// accepted. A zero divisor finishes on the first clock with an error flag.
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  // Holds the not-yet-consumed dividend bits in the upper part and the
  // quotient bits produced so far in the lower part; after WIDTH shifts it
  // holds the complete quotient.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  // Stored partial remainder is always below the divisor, so WIDTH bits
  // suffice between iterations; the shifted value used for the compare and
  // subtract is WIDTH+1 bits.
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dq_next;
  logic             w_last;
  logic             w_dsr_zero;

  // One restoring-division step: shift in the next dividend bit, trial subtract, restore on borrow.
  always_comb begin
    w_shift = {r_prem, r_dvd[WIDTH-1]};
    w_sub   = w_shift - {1'b0, r_dsr};
    // Because the shifted remainder is below 2*divisor, the (WIDTH+1)-bit
    // difference has its top bit set exactly when shifted < divisor, so the
    // top bit acts as the borrow of the compare.
    w_ge    = ~w_sub[WIDTH];
    if (w_ge) begin
      w_rem_next = w_sub[WIDTH-1:0];
    end else begin
      w_rem_next = w_shift[WIDTH-1:0];
    end
    w_dq_next  = {r_dvd[WIDTH-2:0], w_ge};
    w_last     = (r_cnt == CNT_LAST);
    w_dsr_zero = (r_dsr == {WIDTH{1'b0}});
  end

  // Control FSM and datapath registers, including all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dvd       <= {WIDTH{1'b0}};
      r_dsr       <= {WIDTH{1'b0}};
      r_prem      <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_dvd       <= dividend;
            r_dsr       <= divisor;
            r_prem      <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            r_state     <= RUN;
          end else begin
            r_state <= r_state;
          end
        end
        RUN: begin
          if (w_dsr_zero) begin
            // Divide by zero: report all-ones quotient and pass the dividend
            // through as remainder without iterating.
            quotient    <= {WIDTH{1'b1}};
            remainder   <= r_dvd;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_prem <= w_rem_next;
            r_dvd  <= w_dq_next;
            r_cnt  <= r_cnt + CNT_ONE;
            if (w_last) begin
              quotient  <= w_dq_next;
              remainder <= w_rem_next;
              done      <= 1'b1;
              busy      <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider (WIDTH=8).
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       busy;
  logic       div_by_zero;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_prev_q;

  sequential_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Starts a division at the current negedge and checks the full response.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input int elat);
    int lat;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    check_eq({tag, "/acc_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "/acc_done"}, 32'(done), 32'd0);
    check_eq({tag, "/acc_dz"}, 32'(div_by_zero), 32'd0);
    check_eq({tag, "/acc_qhold"}, 32'(quotient), 32'(exp_prev_q));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check_eq({tag, "/overlap"}, 32'(done & busy), 32'd0);
    end while (done !== 1'b1 && lat < 40);
    check_eq({tag, "/latency"}, 32'(lat), 32'(elat));
    check_eq({tag, "/quot"}, 32'(quotient), 32'(eq));
    check_eq({tag, "/rem"}, 32'(remainder), 32'(er));
    check_eq({tag, "/dz"}, 32'(div_by_zero), 32'(edz));
    check_eq({tag, "/busy_end"}, 32'(busy), 32'd0);
    exp_prev_q = eq;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    exp_prev_q = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst/quot", 32'(quotient), 32'd0);
    check_eq("rst/rem", 32'(remainder), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/dz", 32'(div_by_zero), 32'd0);

    // Start on the very first edge after reset release.
    rst = 1'b0;
    run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    repeat (5) @(negedge clk);
    check_eq("hold/done", 32'(done), 32'd1);
    check_eq("hold/quot", 32'(quotient), 32'd14);
    check_eq("hold/rem", 32'(remainder), 32'd2);

    // Boundary operands, each started from DONE.
    run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    run_div("5/10", 8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 8);
    run_div("0/9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 8);

    // Divide by zero.
    run_div("10/0", 8'd10, 8'd0, 8'd255, 8'd10, 1'b1, 1);

    // Second start during RUN must be ignored.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd3;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 1) check_eq("busy_st/dz_clr", 32'(div_by_zero), 32'd0);
      if (e == 2) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (e == 3) start = 1'b0;
      if (e < 8) begin
        check_eq("busy_st/busy", 32'(busy), 32'd1);
        check_eq("busy_st/done", 32'(done), 32'd0);
        check_eq("busy_st/qhold", 32'(quotient), 32'd255);
      end else begin
        check_eq("busy_st/done8", 32'(done), 32'd1);
        check_eq("busy_st/busy8", 32'(busy), 32'd0);
        check_eq("busy_st/quot", 32'(quotient), 32'd66);
        check_eq("busy_st/rem", 32'(remainder), 32'd2);
      end
    end
    exp_prev_q = 8'd66;

    // Reset at edge 4 of RUN.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst/quot", 32'(quotient), 32'd0);
    check_eq("midrst/rem", 32'(remainder), 32'd0);
    check_eq("midrst/done", 32'(done), 32'd0);
    check_eq("midrst/busy", 32'(busy), 32'd0);
    check_eq("midrst/dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    exp_prev_q = 8'd0;
    run_div("15/4", 8'd15, 8'd4, 8'd3, 8'd3, 1'b0, 8);

    // Back-to-back random divisions against a reference quotient/remainder.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
